// File: rtl/bram_pkg.sv
// Shared definitions for the simple dual-port BRAM slice.
//   clogb2      : bits needed to hold a value (0 for value 0)
//   num_lanes   : number of byte-enable lanes for a given word/lane width
//   COLL_*      : read/write collision behaviour selectors
//   ST_*        : clear sequencer state encoding
package bram_pkg;

    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic int num_lanes(input int width, input int byte_width);
        return width / byte_width;
    endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Data + valid shift register placed behind the array read register.
// Data in a stage only advances alongside a valid, so the last stage holds
// the most recent valid word between pulses. reset_n low flushes every stage.
//   clk       : clock
//   reset_n   : synchronous active-low flush
//   in_valid  : valid entering the pipe
//   in_data   : data entering the pipe
//   out_valid : valid leaving the pipe (STAGES cycles later)
//   out_data  : data leaving the pipe
module bram_out_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (STAGES == 0) begin : g_wire
        logic unused_pipe_ctl;
        assign unused_pipe_ctl = &{1'b0, clk, reset_n};
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_regs
        logic [WIDTH-1:0]  data_q [STAGES];
        logic [STAGES-1:0] valid_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                valid_q <= '0;
                for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
            end else begin
                valid_q[0] <= in_valid;
                if (in_valid) data_q[0] <= in_data;
                for (int s = 1; s < STAGES; s++) begin
                    valid_q[s] <= valid_q[s-1];
                    if (valid_q[s-1]) data_q[s] <= data_q[s-1];
                end
            end
        end

        assign out_valid = valid_q[STAGES-1];
        assign out_data  = data_q[STAGES-1];
    end

endmodule

// File: rtl/bram_sdp_pipe.sv
// Simple dual-port single-clock block RAM: port A writes with per-byte
// enables, port B reads with 1..3 cycles of latency and a valid strobe.
// After reset an optional clear sequencer zero-fills the array while both
// ports are ignored.
//   clk, reset_n         : clock, synchronous active-low reset
//   init_busy            : clear sequencer running, ports ignored
//   wea, wea_be, addra,
//   dina                 : write port
//   enb, addrb           : read port
//   doutb, doutb_valid   : read data (held between pulses) and valid pulse
//
// state    | meaning
// ST_CLEAR | sweeping addresses 0..RAM_DEPTH-1 with zeros, ports ignored
// ST_READY | normal operation, ports A and B live
module bram_sdp_pipe
    import bram_pkg::*;
#(
    parameter int RAM_WIDTH      = 128,
    parameter int RAM_DEPTH      = 256,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = "",
    localparam int NB     = num_lanes(RAM_WIDTH, BYTE_WIDTH),
    localparam int ADDR_W = (clogb2(RAM_DEPTH - 1) > 1) ? clogb2(RAM_DEPTH - 1) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 init_busy,
    input  logic                 wea,
    input  logic [NB-1:0]        wea_be,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic [ADDR_W-1:0]    addrb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 doutb_valid
);

    if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..3");
    end
    // Preloading from INIT_FILE is owned by the simulation environment and
    // only meaningful when the array is not swept after reset.
    if (INIT_FILE != "" && CLEAR_ON_RESET == 0) begin : g_init_file
    end

    // One extra bit so a power-of-two depth still fits in the compare.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    logic [RAM_WIDTH-1:0] mem [0:RAM_DEPTH-1];

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;

    assign ready     = (state == ST_READY);
    assign init_busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state    <= ST_READY;
                clr_addr <= '0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    logic wr_ok;
    logic rd_ok;
    logic rd_in_range;
    logic [RAM_WIDTH-1:0] rd_word;

    assign wr_ok       = ready && wea && ({1'b0, addra} < DEPTH_EXT);
    assign rd_ok       = ready && enb;
    assign rd_in_range = ({1'b0, addrb} < DEPTH_EXT);

    // Array write; reset has priority so retained contents survive a reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == ST_CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < NB; i++) begin
                    if (wea_be[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Out-of-range reads return zero; in WRITE_FIRST mode a same-address
    // write forwards its enabled lanes into the word being read.
    always_comb begin
        rd_word = rd_in_range ? mem[addrb] : '0;
        if (COLLISION_MODE == COLL_WRITE_FIRST && wr_ok && addra == addrb) begin
            for (int i = 0; i < NB; i++) begin
                if (wea_be[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic                 rd_valid_s1;
    logic [RAM_WIDTH-1:0] rd_data_s1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_s1 <= 1'b0;
            rd_data_s1  <= '0;
        end else begin
            rd_valid_s1 <= rd_ok;
            if (rd_ok) rd_data_s1 <= rd_word;
        end
    end

    bram_out_pipe #(
        .WIDTH  (RAM_WIDTH),
        .STAGES (READ_LATENCY - 1)
    ) u_out_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_valid_s1),
        .in_data   (rd_data_s1),
        .out_valid (doutb_valid),
        .out_data  (doutb)
    );

endmodule
